// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: sequences J/K drive onto an external JK flip-flop for a
// commanded number of clock edges, then checks the flop's Q against the
// value the operation should have produced and flags any mismatch.
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid && cmd_ready. cmd_ready is high only in IDLE. A request seen
// while busy is neither accepted nor queued; the requester keeps cmd_valid
// (and its payload) asserted until cmd_ready is seen high.
module jk_seq_ctrl #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             jk_j,
   output logic             jk_k,
   input  logic             jk_q,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [7:0]       err_count,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [1:0]       OP_HOLD   = 2'b00;
   localparam logic [1:0]       OP_RESET  = 2'b01;
   localparam logic [1:0]       OP_SET    = 2'b10;
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_ZERO + 1'b1;
   localparam logic [7:0]       ERR_MAX   = 8'hFF;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       op_r;
   logic [CNT_W-1:0] rem;
   logic             exp_q;
   logic             exp_q_nxt;
   logic             accept;
   logic             drive_j_nxt;
   logic             drive_k_nxt;

   assign accept    = cmd_valid && (state == IDLE);
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == CHECK);
   assign err       = (state == CHECK) && (jk_q != exp_q);
   assign state_dbg = state;

   // Expected final Q, computed at accept from the live Q (q_start). A zero
   // count applies no edges, so Q must simply stay put whatever the op.
   always_comb begin
      exp_q_nxt = jk_q;
      if (cmd_count != CNT_ZERO) begin
         case (cmd_op)
            OP_HOLD:  exp_q_nxt = jk_q;
            OP_RESET: exp_q_nxt = 1'b0;
            OP_SET:   exp_q_nxt = 1'b1;
            default:  exp_q_nxt = jk_q ^ cmd_count[0];
         endcase
      end
   end

   // Next-state logic: DRIVE lasts exactly 'count' cycles, CHECK one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (cmd_count != CNT_ZERO) ? DRIVE : CHECK;
            end
         end
         DRIVE: begin
            if (rem == CNT_ONE) begin
               state_nxt = CHECK;
            end
         end
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // J/K are registered, so their next value follows the next state: the op
   // taken from the command port on the accept edge, from op_r afterwards.
   always_comb begin
      drive_j_nxt = 1'b0;
      drive_k_nxt = 1'b0;
      if (state_nxt == DRIVE) begin
         drive_j_nxt = accept ? cmd_op[1] : op_r[1];
         drive_k_nxt = accept ? cmd_op[0] : op_r[0];
      end
   end

   // State register; reset wins over everything, including a pending accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Command capture and repeat counter. rem is loaded with the count and
   // stepped down once per DRIVE cycle; leaving at rem==1 means it never
   // reaches zero inside DRIVE, so a maximum count cannot wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r  <= 2'b00;
         rem   <= CNT_ZERO;
         exp_q <= 1'b0;
      end else if (accept) begin
         op_r  <= cmd_op;
         rem   <= cmd_count;
         exp_q <= exp_q_nxt;
      end else if (state == DRIVE) begin
         rem   <= rem - CNT_ONE;
      end
   end

   // Registered J/K drive to the controlled flip-flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         jk_j <= 1'b0;
         jk_k <= 1'b0;
      end else begin
         jk_j <= drive_j_nxt;
         jk_k <= drive_k_nxt;
      end
   end

   // Saturating count of CHECK cycles that found a mismatch.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= 8'h00;
      end else if (err && (err_count != ERR_MAX)) begin
         err_count <= err_count + 8'h01;
      end
   end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Testbench for jk_seq_ctrl: a behavioural JK flip-flop closes the loop,
// and every command is checked cycle by cycle against outcomes derived
// from the command rules (drive length, final Q, err, err_count).
module tb_jk_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_count = 4'd0;
   logic       jk_j;
   logic       jk_k;
   logic       jk_q;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] err_count;
   logic [1:0] state_dbg;

   // controlled flip-flop model
   logic       ff_q = 1'b0;
   bit         stuck = 1'b0;

   int         vectors = 0;
   int         miscompares = 0;
   int         exp_errs = 0;

   jk_seq_ctrl #(.CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_count (cmd_count),
      .jk_j      (jk_j),
      .jk_k      (jk_k),
      .jk_q      (jk_q),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_count (err_count),
      .state_dbg (state_dbg)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit reached");
   end

   // JK flip-flop under control; 'stuck' forces Q to 0
   always @(posedge clk) begin
      if (stuck) ff_q <= 1'b0;
      else begin
         case ({jk_j, jk_k})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end
   assign jk_q = ff_q;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Final Q from the operation semantics: count edges of HOLD/RESET/SET/TOGGLE.
   function automatic logic model_q(input logic [1:0] op, input int n, input logic q0);
      logic q;
      q = q0;
      for (int i = 0; i < n; i++) begin
         case (op)
            2'b01:   q = 1'b0;
            2'b10:   q = 1'b1;
            2'b11:   q = ~q;
            default: q = q;
         endcase
      end
      return q;
   endfunction

   // At a negedge: wait (bounded) until the block is ready.
   task automatic wait_ready();
      int budget;
      budget = 0;
      while (cmd_ready !== 1'b1 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      chk("ready_wait", cmd_ready, 1'b1);
   endtask

   // Driver + scoreboard for one command. Called at a negedge; returns at
   // the negedge of the cycle after done. If hold_nxt, cmd_valid stays high
   // during the command carrying nop/ncnt, which must be ignored until ready.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input bit stk,
                          input bit hold_nxt, input logic [1:0] nop, input logic [3:0] ncnt);
      logic exp_final;
      logic exp_err;
      logic [7:0] exp_q[$];
      int n;
      n = int'(cnt);
      stuck = stk;
      wait_ready();
      exp_final = model_q(op, n, ff_q);
      exp_err = stk ? (exp_final != 1'b0) : 1'b0;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_count = cnt;
      // expected {busy,ready,j,k,done} per cycle after accept
      for (int c = 1; c <= n + 1; c++) begin
         if (c <= n) exp_q.push_back({3'b000, 1'b1, 1'b0, op[1], op[0], 1'b0});
         else        exp_q.push_back({3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      @(posedge clk);
      for (int c = 1; c <= n + 1; c++) begin
         logic [7:0] e;
         @(negedge clk);
         cmd_valid = hold_nxt;
         cmd_op    = hold_nxt ? nop  : 2'($urandom_range(0, 3));
         cmd_count = hold_nxt ? ncnt : 4'($urandom_range(0, 15));
         e = exp_q.pop_front();
         chk("busy", busy, e[4]);
         chk("cmd_ready", cmd_ready, e[3]);
         chk("jk_j", jk_j, e[2]);
         chk("jk_k", jk_k, e[1]);
         chk("done", done, e[0]);
         if (c == n + 1) begin
            chk("err", err, exp_err);
            chk("final_q", ff_q, stk ? 1'b0 : exp_final);
            if (exp_err && exp_errs < 255) exp_errs++;
         end
      end
      @(negedge clk);
      chk("ready_after", cmd_ready, 1'b1);
      chk("done_after", done, 1'b0);
      chk("err_count", err_count, 8'(exp_errs));
   endtask

   initial begin
      logic [1:0] r_op;
      logic [3:0] r_cnt;
      logic [1:0] n_op;
      logic [3:0] n_cnt;
      bit         hold;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_j", jk_j, 1'b0);
      chk("rst_k", jk_k, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_err_count", err_count, 8'h00);

      // SET count=1 from Q=0
      chk("q_init", ff_q, 1'b0);
      run_cmd(2'b10, 4'd1, 1'b0, 1'b0, 2'b00, 4'd0);
      // force Q back to 0, then TOGGLE 3 -> 1, TOGGLE 2 -> 1
      run_cmd(2'b01, 4'd1, 1'b0, 1'b0, 2'b00, 4'd0);
      run_cmd(2'b11, 4'd3, 1'b0, 1'b0, 2'b00, 4'd0);
      chk("toggle3_q", ff_q, 1'b1);
      run_cmd(2'b11, 4'd2, 1'b0, 1'b0, 2'b00, 4'd0);
      chk("toggle2_q", ff_q, 1'b1);
      // HOLD count=0 and zero-count of other ops
      run_cmd(2'b00, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0);
      run_cmd(2'b10, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0);
      run_cmd(2'b11, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0);

      // stuck-at-0 flop: err_count 0 -> 1, then saturates at 255
      run_cmd(2'b10, 4'd2, 1'b1, 1'b0, 2'b00, 4'd0);
      chk("err_count_first", err_count, 8'h01);
      for (int i = 0; i < 256; i++) run_cmd(2'b10, 4'd2, 1'b1, 1'b0, 2'b00, 4'd0);
      chk("err_count_sat", err_count, 8'hFF);
      stuck = 1'b0;

      // reset in the 2nd DRIVE cycle of TOGGLE count=15
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op = 2'b11;
      cmd_count = 4'd15;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("abort_j1", jk_j, 1'b1);
      @(negedge clk);
      chk("abort_j2", jk_k, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_ready", cmd_ready, 1'b1);
      chk("abort_j", jk_j, 1'b0);
      chk("abort_k", jk_k, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_err_count", err_count, 8'h00);
      exp_errs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("abort_no_done", done, 1'b0);
      end

      // reset beats a simultaneous cmd_valid
      cmd_valid = 1'b1;
      cmd_op = 2'b10;
      cmd_count = 4'd3;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cmd_valid = 1'b0;
      chk("rst_pri_busy", busy, 1'b0);
      chk("rst_pri_j", jk_j, 1'b0);
      @(negedge clk);
      chk("rst_pri_idle", busy, 1'b0);

      // request held during DRIVE is ignored, then taken after done;
      // max count gives 15 DRIVE cycles
      run_cmd(2'b11, 4'd15, 1'b0, 1'b1, 2'b10, 4'd15);
      run_cmd(2'b10, 4'd15, 1'b0, 1'b1, 2'b01, 4'd4);
      run_cmd(2'b01, 4'd4, 1'b0, 1'b0, 2'b00, 4'd0);

      // randomized commands, occasionally back-to-back with held requests
      hold = 1'b0;
      n_op = 2'b00;
      n_cnt = 4'd0;
      for (int i = 0; i < 60; i++) begin
         if (hold) begin
            r_op = n_op;
            r_cnt = n_cnt;
         end else begin
            r_op = 2'($urandom_range(0, 3));
            r_cnt = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         hold = ($urandom_range(0, 2) == 0) && (i != 59);
         n_op = 2'($urandom_range(0, 3));
         n_cnt = 4'($urandom_range(0, 15));
         run_cmd(r_op, r_cnt, ($urandom_range(0, 4) == 0), hold, n_op, n_cnt);
      end
      stuck = 1'b0;
      cmd_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/jk_seq_ctrl.md
JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4: width of the command repeat count.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid  input  1  command request.
REQ-005 The block SHALL have port cmd_ready  output  1  block can accept a command this cycle.
REQ-006 The block SHALL have port cmd_op  input  2  operation: bit1 = J, bit0 = K (00 HOLD, 01 RESET, 10 SET, 11 TOGGLE).
REQ-007 The block SHALL have port cmd_count  input  CNT_W  number of flip-flop clock edges to apply the operation.
REQ-008 The block SHALL have port jk_j  output  1  registered J drive to the controlled JK flip-flop.
REQ-009 The block SHALL have port jk_k  output  1  registered K drive to the controlled JK flip-flop.
REQ-010 The block SHALL have port jk_q  input  1  Q feedback from the controlled flip-flop.
REQ-011 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port err  output  1  mismatch flag, valid only while done=1.
REQ-014 The block SHALL have port err_count  output  8  saturating count of err pulses.

Function
REQ-015 The block SHALL implement states IDLE, DRIVE and CHECK.
REQ-016 cmd_ready SHALL equal (state==IDLE); a command is accepted on an edge where cmd_valid && cmd_ready.
REQ-017 On accept, the block SHALL capture op, count (into remaining counter rem) and q_start = jk_q.
REQ-018 On accept, the next state SHALL be DRIVE if cmd_count != 0, else CHECK.
REQ-019 In DRIVE, jk_j/jk_k SHALL equal the captured op[1]/op[0]; outside DRIVE, both SHALL be 0.
REQ-020 The block SHALL decrement rem once per DRIVE cycle and leave DRIVE for CHECK after exactly count cycles, so the flip-flop sees exactly count edges with the op applied.
REQ-021 Expected Q SHALL be: HOLD -> q_start; RESET -> 0; SET -> 1; TOGGLE -> q_start XOR count[0].
REQ-022 For count=0, expected Q SHALL be q_start for every op.
REQ-023 CHECK SHALL last one cycle, assert done=1 and err=(jk_q != expected), then return to IDLE.
REQ-024 Latency: accept at edge T0, DRIVE during cycles 1..N, done during cycle N+1, cmd_ready again at cycle N+2.
REQ-025 For N=0, done SHALL be asserted in cycle 1.
REQ-026 When err=1, err_count SHALL increment and hold at 255.
REQ-027 A cmd_valid arriving while busy SHALL be ignored and not queued; the requester holds it until cmd_ready=1.
REQ-028 cmd_op/cmd_count changes during DRIVE SHALL have no effect.
REQ-029 Count at maximum (2^CNT_W-1) SHALL be handled with no wrap of rem and exactly 2^CNT_W-1 DRIVE cycles.

Reset
REQ-030 With reset=1 at a rising edge, next cycle SHALL show state=IDLE, jk_j=0, jk_k=0, busy=0, done=0, err=0, err_count=0, cmd_ready=1, regardless of current state, including mid-DRIVE.
REQ-031 No done pulse SHALL be produced for a command aborted by reset.
REQ-032 Reset SHALL have priority over a simultaneous cmd_valid, which is not accepted.

Verification
REQ-033 A bench SHALL cover: flop Q=0, cmd SET count=1 -> jk_j=1,jk_k=0 for 1 cycle; done at cycle 2; Q=1; err=0.
REQ-034 A bench SHALL cover: Q=0, cmd TOGGLE count=3 -> 3 DRIVE cycles with j=k=1; done at cycle 4; Q=1; err=0. Then TOGGLE count=2 -> Q=1; err=0.
REQ-035 A bench SHALL cover: cmd HOLD count=0 -> no DRIVE cycle; done in cycle 1; err=0; j=k=0 throughout.
REQ-036 A bench SHALL cover: flop Q forced stuck at 0, cmd SET count=2 -> done with err=1; err_count 0->1; 256 further failures leave err_count=255.
REQ-037 A bench SHALL cover: reset asserted in 2nd DRIVE cycle of TOGGLE count=15 -> next cycle IDLE, j=k=0, err_count=0, no done.
REQ-038 A bench SHALL cover: cmd_valid held with a new op during DRIVE -> ignored; the new command is accepted the cycle after done (cmd_ready=1), and count=15 yields exactly 15 DRIVE cycles.
